uart_trx_cfg: RTL and testbench



---
 rtl/uart_trx_cfg.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_uart_trx_cfg.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_trx_cfg.sv
// Single-clock UART transceiver with runtime baud/frame configuration.
// TX and RX run independent FSMs, each with its own tick generator and config latch.
module uart_trx_cfg #(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned PRESCALE_WIDTH = 6,
   parameter int unsigned DIV_WIDTH      = 16
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [DIV_WIDTH-1:0]      BAUD_DIV,
   input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
   input  logic                      PAR_EN,
   input  logic                      PAR_TYP,
   input  logic                      STOP2,
   input  logic [DATA_WIDTH-1:0]     TX_DATA,
   input  logic                      TX_VALID,
   output logic                      TX_READY,
   output logic                      TX_OUT,
   input  logic                      RX_IN,
   output logic [DATA_WIDTH-1:0]     RX_DATA,
   output logic                      RX_VALID,
   output logic                      PAR_ERR,
   output logic                      STP_ERR
);

   localparam int unsigned BitW = $clog2(DATA_WIDTH);
   localparam logic [BitW-1:0]           LastBit = BitW'(DATA_WIDTH - 1);
   localparam logic [BitW-1:0]           BitOne  = BitW'(1);
   localparam logic [PRESCALE_WIDTH-1:0] PreOne  = PRESCALE_WIDTH'(1);
   localparam logic [DIV_WIDTH-1:0]      DivOne  = DIV_WIDTH'(1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop1, StStop2} state_e;

   // ---------------------------------------------------------------- TX
   state_e                    tx_state_q, tx_state_d;
   logic [DATA_WIDTH-1:0]     tx_data_q, tx_data_d;
   logic [DIV_WIDTH-1:0]      tx_div_q, tx_div_d, tx_dcnt_q, tx_dcnt_d;
   logic [PRESCALE_WIDTH-1:0] tx_pre_q, tx_pre_d, tx_tcnt_q, tx_tcnt_d;
   logic [BitW-1:0]           tx_bit_q, tx_bit_d;
   logic                      tx_par_en_q, tx_par_en_d, tx_par_typ_q, tx_par_typ_d;
   logic                      tx_stop2_q, tx_stop2_d;
   logic                      tx_out_q, tx_out_d, tx_ready_q, tx_ready_d;
   logic                      tx_tick, tx_bit_end, tx_par;

   always_comb begin
      tx_state_d   = tx_state_q;
      tx_data_d    = tx_data_q;
      tx_div_d     = tx_div_q;
      tx_dcnt_d    = tx_dcnt_q;
      tx_pre_d     = tx_pre_q;
      tx_tcnt_d    = tx_tcnt_q;
      tx_bit_d     = tx_bit_q;
      tx_par_en_d  = tx_par_en_q;
      tx_par_typ_d = tx_par_typ_q;
      tx_stop2_d   = tx_stop2_q;
      tx_ready_d   = tx_ready_q;
      tx_tick      = (tx_dcnt_q == tx_div_q);
      tx_bit_end   = tx_tick && (tx_tcnt_q == tx_pre_q - PreOne);
      tx_par       = (^tx_data_q) ^ tx_par_typ_q;

      if (tx_state_q == StIdle) begin
         if (TX_VALID && tx_ready_q) begin
            tx_state_d   = StStart;
            tx_data_d    = TX_DATA;
            tx_div_d     = BAUD_DIV;
            tx_pre_d     = PRESCALE;
            tx_par_en_d  = PAR_EN;
            tx_par_typ_d = PAR_TYP;
            tx_stop2_d   = STOP2;
            tx_dcnt_d    = '0;
            tx_tcnt_d    = '0;
            tx_bit_d     = '0;
            tx_ready_d   = 1'b0;
         end
      end else begin
         tx_dcnt_d = tx_tick ? '0 : tx_dcnt_q + DivOne;
         if (tx_tick) tx_tcnt_d = tx_bit_end ? '0 : tx_tcnt_q + PreOne;
         if (tx_bit_end) begin
            unique case (tx_state_q)
               StStart: begin
                  tx_state_d = StData;
                  tx_bit_d   = '0;
               end
               StData: begin
                  tx_bit_d = tx_bit_q + BitOne;
                  if (tx_bit_q == LastBit) tx_state_d = tx_par_en_q ? StPar : StStop1;
               end
               StPar: tx_state_d = StStop1;
               StStop1: begin
                  if (tx_stop2_q) begin
                     tx_state_d = StStop2;
                  end else begin
                     tx_state_d = StIdle;
                     tx_ready_d = 1'b1;
                  end
               end
               default: begin
                  tx_state_d = StIdle;
                  tx_ready_d = 1'b1;
               end
            endcase
         end
      end

      // Line value for the bit in progress; the flop adds the one-cycle launch delay.
      unique case (tx_state_q)
         StStart: tx_out_d = 1'b0;
         StData:  tx_out_d = tx_data_q[tx_bit_q];
         StPar:   tx_out_d = tx_par;
         default: tx_out_d = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         tx_state_q   <= StIdle;
         tx_data_q    <= '0;
         tx_div_q     <= '0;
         tx_dcnt_q    <= '0;
         tx_pre_q     <= '0;
         tx_tcnt_q    <= '0;
         tx_bit_q     <= '0;
         tx_par_en_q  <= 1'b0;
         tx_par_typ_q <= 1'b0;
         tx_stop2_q   <= 1'b0;
         tx_out_q     <= 1'b1;
         tx_ready_q   <= 1'b1;
      end else begin
         tx_state_q   <= tx_state_d;
         tx_data_q    <= tx_data_d;
         tx_div_q     <= tx_div_d;
         tx_dcnt_q    <= tx_dcnt_d;
         tx_pre_q     <= tx_pre_d;
         tx_tcnt_q    <= tx_tcnt_d;
         tx_bit_q     <= tx_bit_d;
         tx_par_en_q  <= tx_par_en_d;
         tx_par_typ_q <= tx_par_typ_d;
         tx_stop2_q   <= tx_stop2_d;
         tx_out_q     <= tx_out_d;
         tx_ready_q   <= tx_ready_d;
      end
   end

   assign TX_OUT   = tx_out_q;
   assign TX_READY = tx_ready_q;

   // ---------------------------------------------------------------- RX
   logic                      rx_s1_q, rx_s2_q, rx_sync;
   state_e                    rx_state_q, rx_state_d;
   logic [DIV_WIDTH-1:0]      rx_div_q, rx_div_d, rx_dcnt_q, rx_dcnt_d;
   logic [PRESCALE_WIDTH-1:0] rx_pre_q, rx_pre_d, rx_tcnt_q, rx_tcnt_d, rx_half;
   logic [BitW-1:0]           rx_bit_q, rx_bit_d;
   logic                      rx_par_en_q, rx_par_en_d, rx_par_typ_q, rx_par_typ_d;
   logic                      rx_stop2_q, rx_stop2_d;
   logic [DATA_WIDTH-1:0]     rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
   logic [1:0]                rx_samp_q, rx_samp_d;
   logic                      rx_par_bit_q, rx_par_bit_d, rx_stp_bad_q, rx_stp_bad_d;
   logic                      rx_armed_q, rx_armed_d;
   logic                      rx_valid_q, rx_valid_d, par_err_q, par_err_d, stp_err_q, stp_err_d;
   logic                      rx_tick, rx_bit_end, rx_decide, rx_maj, rx_done;

   always_comb begin
      rx_state_d   = rx_state_q;
      rx_div_d     = rx_div_q;
      rx_dcnt_d    = rx_dcnt_q;
      rx_pre_d     = rx_pre_q;
      rx_tcnt_d    = rx_tcnt_q;
      rx_bit_d     = rx_bit_q;
      rx_par_en_d  = rx_par_en_q;
      rx_par_typ_d = rx_par_typ_q;
      rx_stop2_d   = rx_stop2_q;
      rx_shift_d   = rx_shift_q;
      rx_samp_d    = rx_samp_q;
      rx_par_bit_d = rx_par_bit_q;
      rx_stp_bad_d = rx_stp_bad_q;
      rx_data_d    = rx_data_q;
      par_err_d    = par_err_q;
      stp_err_d    = stp_err_q;
      rx_valid_d   = 1'b0;
      rx_done      = 1'b0;
      rx_sync      = rx_s2_q;
      // A break must return high before another start can be recognised.
      rx_armed_d   = rx_armed_q | rx_sync;
      rx_half      = rx_pre_q >> 1;
      rx_tick      = (rx_dcnt_q == rx_div_q);
      rx_bit_end   = rx_tick && (rx_tcnt_q == rx_pre_q - PreOne);
      rx_decide    = rx_tick && (rx_tcnt_q == rx_half + PreOne);
      rx_maj       = (rx_samp_q[0] & rx_samp_q[1]) | (rx_samp_q[0] & rx_sync) |
                     (rx_samp_q[1] & rx_sync);

      if (rx_state_q == StIdle) begin
         if (!rx_sync && rx_armed_q) begin
            rx_state_d   = StStart;
            rx_div_d     = BAUD_DIV;
            rx_pre_d     = PRESCALE;
            rx_par_en_d  = PAR_EN;
            rx_par_typ_d = PAR_TYP;
            rx_stop2_d   = STOP2;
            rx_dcnt_d    = '0;
            rx_tcnt_d    = '0;
            rx_bit_d     = '0;
            rx_stp_bad_d = 1'b0;
         end
      end else begin
         rx_dcnt_d = rx_tick ? '0 : rx_dcnt_q + DivOne;
         if (rx_tick) rx_tcnt_d = rx_bit_end ? '0 : rx_tcnt_q + PreOne;
         if (rx_tick && rx_tcnt_q == rx_half - PreOne) rx_samp_d[0] = rx_sync;
         if (rx_tick && rx_tcnt_q == rx_half) rx_samp_d[1] = rx_sync;
         if (rx_bit_end) begin
            unique case (rx_state_q)
               StStart: begin
                  rx_state_d = StData;
                  rx_bit_d   = '0;
               end
               StData: begin
                  rx_bit_d = rx_bit_q + BitOne;
                  if (rx_bit_q == LastBit) rx_state_d = rx_par_en_q ? StPar : StStop1;
               end
               StPar:   rx_state_d = StStop1;
               StStop1: rx_state_d = StStop2;
               default: rx_state_d = StIdle;
            endcase
         end
         // With PRESCALE=4 the decision and bit end share a tick; the decision wins.
         if (rx_decide) begin
            unique case (rx_state_q)
               StStart: if (rx_maj) rx_state_d = StIdle;
               StData:  rx_shift_d = {rx_maj, rx_shift_q[DATA_WIDTH-1:1]};
               StPar:   rx_par_bit_d = rx_maj;
               StStop1: begin
                  if (rx_stop2_q) rx_stp_bad_d = ~rx_maj;
                  else rx_done = 1'b1;
               end
               StStop2: rx_done = 1'b1;
               default: rx_done = 1'b0;
            endcase
         end
         if (rx_done) begin
            rx_state_d = StIdle;
            rx_armed_d = 1'b0;
            rx_valid_d = 1'b1;
            rx_data_d  = rx_shift_q;
            par_err_d  = rx_par_en_q & (rx_par_bit_q ^ (^rx_shift_q) ^ rx_par_typ_q);
            stp_err_d  = rx_stp_bad_q | ~rx_maj;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rx_s1_q      <= 1'b1;
         rx_s2_q      <= 1'b1;
         rx_state_q   <= StIdle;
         rx_div_q     <= '0;
         rx_dcnt_q    <= '0;
         rx_pre_q     <= '0;
         rx_tcnt_q    <= '0;
         rx_bit_q     <= '0;
         rx_par_en_q  <= 1'b0;
         rx_par_typ_q <= 1'b0;
         rx_stop2_q   <= 1'b0;
         rx_shift_q   <= '0;
         rx_samp_q    <= '0;
         rx_par_bit_q <= 1'b0;
         rx_stp_bad_q <= 1'b0;
         rx_armed_q   <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
      end else begin
         rx_s1_q      <= RX_IN;
         rx_s2_q      <= rx_s1_q;
         rx_state_q   <= rx_state_d;
         rx_div_q     <= rx_div_d;
         rx_dcnt_q    <= rx_dcnt_d;
         rx_pre_q     <= rx_pre_d;
         rx_tcnt_q    <= rx_tcnt_d;
         rx_bit_q     <= rx_bit_d;
         rx_par_en_q  <= rx_par_en_d;
         rx_par_typ_q <= rx_par_typ_d;
         rx_stop2_q   <= rx_stop2_d;
         rx_shift_q   <= rx_shift_d;
         rx_samp_q    <= rx_samp_d;
         rx_par_bit_q <= rx_par_bit_d;
         rx_stp_bad_q <= rx_stp_bad_d;
         rx_armed_q   <= rx_armed_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         par_err_q    <= par_err_d;
         stp_err_q    <= stp_err_d;
      end
   end

   assign RX_DATA  = rx_data_q;
   assign RX_VALID = rx_valid_q;
   assign PAR_ERR  = par_err_q;
   assign STP_ERR  = stp_err_q;

endmodule

// File: tb/tb_uart_trx_cfg.sv
// Directed bench for uart_trx_cfg: TX frame vectors with loopback RX, back-to-back TX,
// RX error/noise/glitch/break sequences and mid-frame reset.
module tb_uart_trx_cfg;

   typedef struct {
      logic [7:0]  data;
      logic        par_en;
      logic        par_typ;
      logic        stop2;
      logic [15:0] baud;
      logic [5:0]  pre;
      int          nbits;
      logic [11:0] frame;   // wire bits, index 0 = start bit
   } tx_vec_t;

   logic        clk, rst;
   logic [15:0] baud_div;
   logic [5:0]  prescale;
   logic        par_en, par_typ, stop2;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready, tx_out;
   logic        rx_in, rx_drv, loop_en;
   logic [7:0]  rx_data;
   logic        rx_valid, par_err, stp_err;

   int checks = 0;
   int errors = 0;
   int vcnt   = 0;

   assign rx_in = loop_en ? tx_out : rx_drv;

   uart_trx_cfg #(
      .DATA_WIDTH    (8),
      .PRESCALE_WIDTH(6),
      .DIV_WIDTH     (16)
   ) dut (
      .CLK     (clk),
      .RST     (rst),
      .BAUD_DIV(baud_div),
      .PRESCALE(prescale),
      .PAR_EN  (par_en),
      .PAR_TYP (par_typ),
      .STOP2   (stop2),
      .TX_DATA (tx_data),
      .TX_VALID(tx_valid),
      .TX_READY(tx_ready),
      .TX_OUT  (tx_out),
      .RX_IN   (rx_in),
      .RX_DATA (rx_data),
      .RX_VALID(rx_valid),
      .PAR_ERR (par_err),
      .STP_ERR (stp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always begin
      @(posedge clk);
      #1;
      if (rx_valid === 1'b1) vcnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_cfg(input logic pe, input logic pt, input logic s2, input logic [15:0] bd,
                          input logic [5:0] ps);
      par_en   = pe;
      par_typ  = pt;
      stop2    = s2;
      baud_div = bd;
      prescale = ps;
   endtask

   // Sends one frame from the table, checks every bit mid-point, READY timing and loopback RX.
   task automatic run_vec(input tx_vec_t v, input int idx);
      int bw, nb, base;
      bw = int'(v.pre) * (int'(v.baud) + 1);
      nb = v.nbits * bw;
      set_cfg(v.par_en, v.par_typ, v.stop2, v.baud, v.pre);
      loop_en  = 1'b1;
      tx_data  = v.data;
      tx_valid = 1'b1;
      base     = vcnt;
      @(negedge clk);
      tx_valid = 1'b0;
      chk($sformatf("v%0d ready_after_accept", idx), tx_ready, 0);
      for (int m = 1; m <= nb + 1; m++) begin
         @(negedge clk);
         if ((m - 1) % bw == bw / 2 && (m - 1) / bw < v.nbits)
            chk($sformatf("v%0d bit%0d", idx, (m - 1) / bw), tx_out, v.frame[(m - 1) / bw]);
         if (m == nb - 1) chk($sformatf("v%0d ready_busy", idx), tx_ready, 0);
         if (m == nb + 1) begin
            chk($sformatf("v%0d ready_end", idx), tx_ready, 1);
            chk($sformatf("v%0d idle_line", idx), tx_out, 1);
         end
      end
      repeat (4) @(negedge clk);
      chk($sformatf("v%0d rx_count", idx), vcnt, base + 1);
      chk($sformatf("v%0d rx_data", idx), rx_data, v.data);
      chk($sformatf("v%0d par_err", idx), par_err, 0);
      chk($sformatf("v%0d stp_err", idx), stp_err, 0);
   endtask

   // Drives a frame on RX_IN at 8 cycles per bit; noise flips the middle majority sample.
   task automatic send_rx(input logic [11:0] frame, input int n, input bit noise);
      for (int b = 0; b < n; b++) begin
         for (int c = 0; c < 8; c++) begin
            rx_drv = frame[b] ^ (noise && c == 5);
            @(negedge clk);
         end
      end
      rx_drv = 1'b1;
   endtask

   tx_vec_t vecs [7];
   tx_vec_t clean;
   int      base;

   initial begin
      vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 16'd0, 6'd8,  10, 12'h34A};  // 8N1
      vecs[1] = '{8'h00, 1'b1, 1'b0, 1'b0, 16'd0, 6'd8,  11, 12'h400};  // 8E1
      vecs[2] = '{8'h55, 1'b1, 1'b0, 1'b0, 16'd1, 6'd4,  11, 12'h4AA};  // 8E1, min prescale
      vecs[3] = '{8'hFF, 1'b1, 1'b0, 1'b0, 16'd0, 6'd6,  11, 12'h5FE};  // 8E1
      vecs[4] = '{8'h3C, 1'b1, 1'b1, 1'b1, 16'd0, 6'd8,  12, 12'hE78};  // 8O2
      vecs[5] = '{8'h01, 1'b1, 1'b1, 1'b0, 16'd2, 6'd4,  11, 12'h402};  // 8O1
      vecs[6] = '{8'h80, 1'b0, 1'b0, 1'b1, 16'd0, 6'd32, 11, 12'h700};  // 8N2, max prescale
      clean   = '{8'h5A, 1'b0, 1'b0, 1'b0, 16'd0, 6'd8,  10, 12'h2B4};

      rst      = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      rx_drv   = 1'b1;
      loop_en  = 1'b0;
      set_cfg(1'b0, 1'b0, 1'b0, 16'd0, 6'd8);
      repeat (3) @(negedge clk);
      chk("rst tx_out", tx_out, 1);
      chk("rst tx_ready", tx_ready, 1);
      chk("rst rx_data", rx_data, 0);
      chk("rst rx_valid", rx_valid, 0);
      chk("rst par_err", par_err, 0);
      chk("rst stp_err", stp_err, 0);
      rst = 1'b1;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // Back-to-back 8O2 with TX_VALID held: one idle cycle between frames.
      set_cfg(1'b1, 1'b1, 1'b1, 16'd1, 6'd16);
      loop_en  = 1'b1;
      tx_data  = 8'h3C;
      tx_valid = 1'b1;
      base     = vcnt;
      @(negedge clk);
      tx_data = 8'hFF;
      for (int m = 1; m <= 780; m++) begin
         @(negedge clk);
         if (m == 17)  chk("b2b start1", tx_out, 0);
         if (m == 305) chk("b2b parity1", tx_out, 1);
         if (m == 384) chk("b2b stop2_1", tx_out, 1);
         if (m == 385) begin
            chk("b2b gap", tx_out, 1);
            chk("b2b accept2", tx_ready, 0);
            tx_valid = 1'b0;
         end
         if (m == 386) chk("b2b start2", tx_out, 0);
         if (m == 690) chk("b2b parity2", tx_out, 1);
         if (m == 770) chk("b2b ready2", tx_ready, 1);
      end
      repeat (4) @(negedge clk);
      chk("b2b rx_count", vcnt, base + 2);
      chk("b2b rx_data", rx_data, 8'hFF);
      chk("b2b par_err", par_err, 0);

      // RX error and noise frames, 8 cycles per bit.
      loop_en = 1'b0;
      set_cfg(1'b1, 1'b0, 1'b0, 16'd0, 6'd8);
      base = vcnt;
      send_rx(12'h61E, 11, 1'b0);
      repeat (20) @(negedge clk);
      chk("perr count", vcnt, base + 1);
      chk("perr data", rx_data, 8'h0F);
      chk("perr par_err", par_err, 1);
      chk("perr stp_err", stp_err, 0);

      set_cfg(1'b0, 1'b0, 1'b0, 16'd0, 6'd8);
      base = vcnt;
      send_rx(12'h12C, 10, 1'b0);
      repeat (20) @(negedge clk);
      chk("serr count", vcnt, base + 1);
      chk("serr data", rx_data, 8'h96);
      chk("serr stp_err", stp_err, 1);
      chk("serr par_err", par_err, 0);

      base = vcnt;
      send_rx(12'h386, 10, 1'b1);
      repeat (20) @(negedge clk);
      chk("noise count", vcnt, base + 1);
      chk("noise data", rx_data, 8'hC3);
      chk("noise stp_err", stp_err, 0);

      // Two-cycle start glitch is rejected.
      base   = vcnt;
      rx_drv = 1'b0;
      repeat (2) @(negedge clk);
      rx_drv = 1'b1;
      repeat (100) @(negedge clk);
      chk("glitch count", vcnt, base);
      chk("glitch data", rx_data, 8'hC3);

      // Break: one errored frame, then silence until the line recovers.
      base   = vcnt;
      rx_drv = 1'b0;
      repeat (160) @(negedge clk);
      chk("break count", vcnt, base + 1);
      chk("break data", rx_data, 8'h00);
      chk("break stp_err", stp_err, 1);
      chk("break par_err", par_err, 0);
      rx_drv = 1'b1;
      repeat (60) @(negedge clk);
      chk("break after_high", vcnt, base + 1);

      // Reset during TX bit 4 (RX also mid-frame through loopback).
      set_cfg(1'b0, 1'b0, 1'b0, 16'd0, 6'd8);
      loop_en  = 1'b1;
      tx_data  = 8'h5A;
      tx_valid = 1'b1;
      base     = vcnt;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (37) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mrst tx_out", tx_out, 1);
      chk("mrst tx_ready", tx_ready, 1);
      chk("mrst rx_valid", rx_valid, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (150) @(negedge clk);
      chk("mrst no_valid", vcnt, base);
      chk("mrst rx_data", rx_data, 0);
      run_vec(clean, 7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
